hs_burst_ctrl: RTL

Controls one C-PHY HS transmit burst around the HS_Sequencer. On a PPI-style request it drives the prepare period, the preamble and sync phases, and data streaming. It can re-insert a sync word every SYNC_INTERVAL data words. It closes the burst with the post phase and supervises every sequencer phase with a watchdog. It sits between the lane PPI interface and the HS_Sequencer / symbol-mux datapath.

---
 rtl/hs_ctrl_pkg.sv | 21 ++
 rtl/hs_burst_ctrl_if.sv | 14 +
 rtl/hs_phase_timer.sv | 21 ++
 rtl/hs_burst_ctrl.sv | 54 +++++
 4 files changed

// File: rtl/hs_ctrl_pkg.sv
// hs_ctrl_pkg: burst states, symbol-mux select codes and the per-state output decode.
package hs_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, PREPARE, PREAMBLE, SYNC, DATA, POST} state_t;
  localparam logic [1:0] SEL_LP = 2'b00;
  localparam logic [1:0] SEL_SEQ = 2'b01;
  localparam logic [1:0] SEL_DATA = 2'b10;
  typedef struct packed {
    logic seq_en;
    logic sync;
    logic post;
    logic drv_en;
    logic [1:0] sel;
    logic ready;
  } out_t;
  function automatic out_t decode(state_t s);
    logic seq;
    seq = s inside {PREAMBLE, SYNC, POST};
    return '{seq_en: seq, sync: s == SYNC, post: s == POST, drv_en: s != IDLE,
             sel: s == DATA ? SEL_DATA : seq ? SEL_SEQ : SEL_LP, ready: s == DATA};
  endfunction
endpackage

// File: rtl/hs_burst_ctrl_if.sv
// hs_burst_ctrl_if: PPI request/data handshake plus HS_Sequencer control and status.
interface hs_burst_ctrl_if;
  logic TxRequestHS, TxWordValid, Pre_Done, Sync_Done, Post_Done;
  logic Sequencer_En, Sync, Post, HS_Drv_En, TxReadyHS, Burst_Err;
  logic [1:0] TxSymSel;
  modport master (
    output TxRequestHS, TxWordValid, Pre_Done, Sync_Done, Post_Done,
    input Sequencer_En, Sync, Post, HS_Drv_En, TxSymSel, TxReadyHS, Burst_Err
  );
  modport slave (
    input TxRequestHS, TxWordValid, Pre_Done, Sync_Done, Post_Done,
    output Sequencer_En, Sync, Post, HS_Drv_En, TxSymSel, TxReadyHS, Burst_Err
  );
endinterface

// File: rtl/hs_phase_timer.sv
// hs_phase_timer: per-phase cycle counter with prepare-length and watchdog compares.
module hs_phase_timer #(
  parameter int PREP_CYCLES = 4,
  parameter int TIMEOUT = 32
) (
  input logic SymClk,
  input logic reset,
  input logic clr,
  input logic en,
  output logic prep_done,
  output logic expired
);
  localparam int CW = $clog2((PREP_CYCLES > TIMEOUT ? PREP_CYCLES : TIMEOUT) + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge SymClk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clr ? '0 : cnt + CW'(en);
  // flags fire on the last cycle of the window so the state change lands exactly on the limit
  assign prep_done = cnt == CW'(PREP_CYCLES - 1);
  assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/hs_burst_ctrl.sv
// hs_burst_ctrl: C-PHY HS transmit burst sequencing with periodic sync re-insertion
// and a watchdog over every HS_Sequencer phase.
module hs_burst_ctrl
  import hs_ctrl_pkg::*;
#(
  parameter int PREP_CYCLES = 4,
  parameter int SYNC_INTERVAL = 0,
  parameter int TIMEOUT = 32
) (
  input logic SymClk,
  input logic reset,
  hs_burst_ctrl_if.slave bus
);
  localparam int WW = SYNC_INTERVAL == 0 ? 1 : $clog2(SYNC_INTERVAL + 1);
  localparam logic [WW-1:0] WLAST = WW'(SYNC_INTERVAL == 0 ? 0 : SYNC_INTERVAL - 1);
  state_t state, nxt;
  logic [WW-1:0] words;
  logic prep_done, expired, seq_phase, done, timeout, acc, resync;
  assign seq_phase = state inside {PREAMBLE, SYNC, POST};
  assign done = state == PREAMBLE ? bus.Pre_Done :
                state == SYNC ? bus.Sync_Done : (state == POST) && bus.Post_Done;
  assign timeout = seq_phase && !done && expired;
  assign acc = bus.TxReadyHS && bus.TxWordValid;
  assign resync = SYNC_INTERVAL != 0 && acc && words == WLAST;
  always_comb
    nxt = timeout ? IDLE :
          state == IDLE ? (bus.TxRequestHS ? PREPARE : IDLE) :
          state == PREPARE ? (prep_done ? PREAMBLE : PREPARE) :
          state == PREAMBLE ? (bus.Pre_Done ? SYNC : PREAMBLE) :
          state == SYNC ? (bus.Sync_Done ? DATA : SYNC) :
          state == DATA ? (!bus.TxRequestHS ? POST : resync ? SYNC : DATA) :
          bus.Post_Done ? IDLE : POST;
  hs_phase_timer #(.PREP_CYCLES(PREP_CYCLES), .TIMEOUT(TIMEOUT)) u_timer (
    .SymClk(SymClk),
    .reset(reset),
    .clr(nxt != state),
    .en(state == PREPARE || seq_phase),
    .prep_done(prep_done),
    .expired(expired)
  );
  // outputs are decoded from the next state so they line up with the registered state
  always_ff @(posedge SymClk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      words <= '0;
      bus.Burst_Err <= 1'b0;
      {bus.Sequencer_En, bus.Sync, bus.Post, bus.HS_Drv_En, bus.TxSymSel, bus.TxReadyHS} <= '0;
    end else begin
      state <= nxt;
      words <= state != DATA ? '0 : words + WW'(acc && SYNC_INTERVAL != 0);
      bus.Burst_Err <= timeout;
      {bus.Sequencer_En, bus.Sync, bus.Post, bus.HS_Drv_En, bus.TxSymSel, bus.TxReadyHS} <= decode(nxt);
    end
endmodule
